gng_interp_pq: RTL and testbench

Parametrised piecewise-quadratic interpolator for the Gaussian noise generator, the next generation of the fixed 64-bit/16-bit interpolation stage. It maps a uniform random word to a signed Gaussian sample. The block uses leading-zero segmentation, a normalised mantissa and a runtime-loadable coefficient table. It sits between the uniform source and the noise consumer and adds a full valid/ready handshake with backpressure.

---
 rtl/gng_interp_pq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_gng_interp_pq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gng_interp_pq.sv
// ---------------------------------------------------------------------------
// gng_interp_pq
//
// Piecewise-quadratic interpolator for the Gaussian noise generator. A uniform
// random word u is split into a sign bit, a sub-segment offset and a value
// field v. The segment is selected by the leading-zero count of v, and the
// mantissa x is the field of v just below its leading one. A runtime-loadable
// coefficient table supplies {c2, c1, c0} for each {lz, off} address, and the
// Horner-form polynomial c0 + x*(c1 + x*c2) (in Q0.X_W) is rounded, limited
// and signed to give the output sample.
//
// Pipeline (one register per stage, 6-cycle latency, 1 sample/cycle):
//   S1 field extraction + leading-zero detect
//   S2 normalise shift + coefficient table read
//   S3 t1 = c1 + (c2*x >>> X_W)
//   S4 t1*x >>> X_W
//   S5 t2 = c0 + ...,  r = round(t2 >>> RND_SH)
//   S6 limit, negate, output register
// The whole pipeline advances together whenever the output register is free
// or being drained; otherwise every stage holds.
//
// Configuration macro:
//   GNG_INTERP_SAT_EN  defined   -> magnitude clipped to 2^(OUT_W-1)-1 and
//                                   sat_flag latches on any clipped sample.
//                      undefined -> magnitude wraps mod 2^(OUT_W-1) and
//                                   sat_flag is tied low.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   in_valid/in_ready    input handshake, in_data = uniform word u
//   out_valid/out_ready  output handshake, out_data = signed sample
//   cfg_we/cfg_addr/cfg_data  table write port, entry = {c2, c1, c0}
//   sat_flag             sticky saturation indicator
// ---------------------------------------------------------------------------
module gng_interp_pq #(
  parameter int IN_W     = 64,
  parameter int SEG_BITS = 2,
  parameter int X_W      = 15,
  parameter int C_W      = 18,
  parameter int OUT_W    = 16,
  parameter int RND_SH   = 3,
  parameter int ADDR_W   = $clog2(IN_W - SEG_BITS) + SEG_BITS
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [3*C_W-1:0]   cfg_data,
  output logic               sat_flag
);

  // Width of the value field v and of its leading-zero count.
  localparam int L     = IN_W - SEG_BITS - 1;
  localparam int LZ_W  = ADDR_W - SEG_BITS;
  localparam int DEPTH = 2 ** ADDR_W;
  // v padded with X_W zeros so x is zero-filled when v has few bits left.
  localparam int NRM_W = L + X_W;
  // c2 (signed) times x (unsigned, carried as X_W+1 signed).
  localparam int P2_W  = C_W + X_W + 1;
  // c1 + (c2*x >>> X_W) stays within one extra bit of C_W.
  localparam int T1_W  = C_W + 1;
  localparam int P4_W  = T1_W + X_W + 1;
  // c0 (unsigned) + signed product + rounding constant, with headroom.
  localparam int T2_W  = C_W + 3;

  // -------------------------------------------------------------------------
  // Handshake: the pipeline moves as a whole unless a valid output is stuck.
  // -------------------------------------------------------------------------
  logic       adv;
  logic [5:0] vld;   // vld[k] = stage S(k+1) holds a live sample

  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld[5];

  // -------------------------------------------------------------------------
  // Coefficient table
  // -------------------------------------------------------------------------
  // NOTE: the table has no reset; it is pure storage that software loads
  // before use, and leaving it out of reset lets it map onto RAM.
  logic [3*C_W-1:0] coef_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cfg_we) coef_mem[cfg_addr] <= cfg_data;
  end

  // -------------------------------------------------------------------------
  // S1 combinational: field extraction and leading-zero detect
  // -------------------------------------------------------------------------
  logic [L-1:0]    v_in;
  logic [LZ_W-1:0] lz_in;

  assign v_in = in_data[IN_W-1:SEG_BITS+1];

  // Scanning upward lets the highest set bit win; an all-zero v keeps L.
  // NOTE: lz_in gets its default before the loop so every path assigns it
  // and no latch is inferred.
  always_comb begin
    lz_in = LZ_W'(L);
    for (int i = 0; i < L; i++) begin
      if (v_in[i]) lz_in = LZ_W'(L - 1 - i);
    end
  end

  logic               s1_sign;
  logic [SEG_BITS-1:0] s1_off;
  logic [L-1:0]       s1_v;
  logic [LZ_W-1:0]    s1_lz;

  // -------------------------------------------------------------------------
  // S2 combinational: normalise so the leading one sits at the top, then x
  // is the X_W bits directly beneath it.
  // -------------------------------------------------------------------------
  logic [NRM_W-1:0]  nrm;
  logic [X_W-1:0]    x_nrm;
  logic [ADDR_W-1:0] s1_addr;

  assign nrm     = {s1_v, {X_W{1'b0}}} << s1_lz;
  assign x_nrm   = X_W'(nrm >> (L - 1));
  assign s1_addr = {s1_lz, s1_off};

  logic                  s2_sign;
  logic [X_W-1:0]        s2_x;
  logic [C_W-1:0]        s2_c0;
  logic signed [C_W-1:0] s2_c1;
  logic signed [C_W-1:0] s2_c2;

  // -------------------------------------------------------------------------
  // S3 combinational: t1 = c1 + floor(c2*x / 2^X_W)
  // -------------------------------------------------------------------------
  logic signed [P2_W-1:0] p2;
  logic signed [T1_W-1:0] t1_nx;

  assign p2    = P2_W'(s2_c2) * P2_W'($signed({1'b0, s2_x}));
  assign t1_nx = T1_W'(P2_W'(s2_c1) + (p2 >>> X_W));

  logic                   s3_sign;
  logic [X_W-1:0]         s3_x;
  logic [C_W-1:0]         s3_c0;
  logic signed [T1_W-1:0] s3_t1;

  // -------------------------------------------------------------------------
  // S4 combinational: floor(t1*x / 2^X_W)
  // -------------------------------------------------------------------------
  logic signed [P4_W-1:0] p4;
  logic signed [T2_W-1:0] prod_nx;

  assign p4      = P4_W'(s3_t1) * P4_W'($signed({1'b0, s3_x}));
  assign prod_nx = T2_W'(p4 >>> X_W);

  logic                   s4_sign;
  logic [C_W-1:0]         s4_c0;
  logic signed [T2_W-1:0] s4_prod;

  // -------------------------------------------------------------------------
  // S5 combinational: t2 = c0 + product, round half-up by the final shift
  // -------------------------------------------------------------------------
  logic signed [T2_W-1:0] sum;

  assign sum = T2_W'($signed({1'b0, s4_c0})) + s4_prod
             + T2_W'(2 ** (RND_SH - 1));

  logic                   s5_sign;
  logic signed [T2_W-1:0] s5_r;

  // -------------------------------------------------------------------------
  // S6 combinational: negative results collapse to zero, large ones are
  // either clipped or wrapped, then the sign bit of u is applied.
  // -------------------------------------------------------------------------
  logic [OUT_W-2:0] mag;
  logic [OUT_W-1:0] res;

`ifdef GNG_INTERP_SAT_EN
  logic clip;

  // r is known non-negative here, so any set bit above the magnitude field
  // means r exceeds the largest representable magnitude.
  always_comb begin
    clip = 1'b0;
    mag  = '0;
    if (!s5_r[T2_W-1]) begin
      clip = |s5_r[T2_W-2:OUT_W-1];
      mag  = clip ? '1 : s5_r[OUT_W-2:0];
    end
  end
`else
  logic unused_r_hi;

  // Wrapping keeps only the low magnitude bits of a non-negative r.
  always_comb begin
    mag = '0;
    if (!s5_r[T2_W-1]) mag = s5_r[OUT_W-2:0];
  end

  assign unused_r_hi = |s5_r[T2_W-2:OUT_W-1];
`endif

  assign res = s5_sign ? -{1'b0, mag} : {1'b0, mag};

  // -------------------------------------------------------------------------
  // Datapath registers. Only the valid bits need a reset: a stage's data is
  // never looked at unless its valid bit is set.
  // -------------------------------------------------------------------------
  // NOTE: the table read uses the pre-edge contents because the write above
  // is non-blocking, which gives read-before-write on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= in_data[0];
      s1_off  <= in_data[SEG_BITS:1];
      s1_v    <= v_in;
      s1_lz   <= lz_in;

      s2_sign <= s1_sign;
      s2_x    <= x_nrm;
      {s2_c2, s2_c1, s2_c0} <= coef_mem[s1_addr];

      s3_sign <= s2_sign;
      s3_x    <= s2_x;
      s3_c0   <= s2_c0;
      s3_t1   <= t1_nx;

      s4_sign <= s3_sign;
      s4_c0   <= s3_c0;
      s4_prod <= prod_nx;

      s5_sign <= s4_sign;
      s5_r    <= sum >>> RND_SH;
    end
  end

  // -------------------------------------------------------------------------
  // Control and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld      <= '0;
      out_data <= '0;
    end else if (adv) begin
      vld <= {vld[4:0], in_valid};
      if (vld[4]) out_data <= res;
    end
  end

`ifdef GNG_INTERP_SAT_EN
  // Rises in the same edge that presents the clipped sample at the output.
  always_ff @(posedge clk) begin
    if (!rstn)                         sat_flag <= 1'b0;
    else if (adv && vld[4] && clip)    sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_gng_interp_pq.sv
// ---------------------------------------------------------------------------
// tb_gng_interp_pq
//
// Self-checking bench for gng_interp_pq with default parameters. Expected
// samples come from a behavioural model that evaluates the interpolation
// rules with 64-bit integer arithmetic against a shadow copy of the table.
// Build with or without GNG_INTERP_SAT_EN; expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_gng_interp_pq;

  localparam int IN_W     = 64;
  localparam int SEG_BITS = 2;
  localparam int X_W      = 15;
  localparam int C_W      = 18;
  localparam int OUT_W    = 16;
  localparam int RND_SH   = 3;
  localparam int ADDR_W   = 8;
  localparam int L        = IN_W - SEG_BITS - 1;
  localparam int MAG_MAX  = 2 ** (OUT_W - 1) - 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [3*C_W-1:0]  cfg_data = '0;
  logic              sat_flag;

  int n_checks = 0;
  int n_pass   = 0;

  // Shadow of the coefficient table.
  int m_c0 [2**ADDR_W];
  int m_c1 [2**ADDR_W];
  int m_c2 [2**ADDR_W];

  always #5 clk = ~clk;

  gng_interp_pq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .sat_flag  (sat_flag)
  );

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] u);
    longint v, x, t1, t2, r, mag, res;
    int     p, lz, a;
    v = longint'(u >> (SEG_BITS + 1));
    p = -1;                                   // position of highest set bit
    for (int i = 0; i < L; i++) if (v[i]) p = i;
    lz = (p < 0) ? L : L - 1 - p;
    if (p < 0) x = 0;
    else begin
      x = v - (longint'(1) << p);             // bits below the leading one
      x = (p >= X_W) ? (x >> (p - X_W)) : (x << (X_W - p));
    end
    a  = lz * (2 ** SEG_BITS) + int'(u[SEG_BITS:1]);
    t1 = longint'(m_c1[a]) + ((longint'(m_c2[a]) * x) >>> X_W);
    t2 = longint'(m_c0[a]) + ((t1 * x) >>> X_W);
    r  = (t2 + (longint'(1) << (RND_SH - 1))) >>> RND_SH;
    if (r < 0) mag = 0;
    else begin
`ifdef GNG_INTERP_SAT_EN
      mag = (r > MAG_MAX) ? longint'(MAG_MAX) : r;
`else
      mag = r % (longint'(MAG_MAX) + 1);
`endif
    end
    res = u[0] ? -mag : mag;
    return OUT_W'(res);
  endfunction

  function automatic logic [IN_W-1:0] gen_u();
    logic [IN_W-1:0] u;
    u = {$urandom, $urandom};
    u = u >> $urandom_range(0, IN_W - 1);
    u[SEG_BITS:0] = (SEG_BITS + 1)'($urandom);
    return u;
  endfunction

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic cfg_write(input int a, input int c0, input int c1, input int c2);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(a);
    cfg_data = {C_W'(c2), C_W'(c1), C_W'(c0)};
    m_c0[a] = c0; m_c1[a] = c1; m_c2[a] = c2;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Sends one word into an idle pipeline; lat counts clock edges until the
  // sample shows up (capped at 20).
  task automatic run_one(input logic [IN_W-1:0] u, output int lat,
                         output logic [OUT_W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = u; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = out_data;
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data); else n_pass++;
    n_checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat_flag: got %b want 0", sat_flag); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    rstn = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_constant();
    int lat; logic [OUT_W-1:0] d;
    cfg_write(0, 1000, 0, 0);
    run_one(64'h8000_0000_0000_0000, lat, d);
    n_checks++; if (lat != 6) $display("FAIL const_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (d !== 16'd125) $display("FAIL const_pos: got %h want 007d", d); else n_pass++;
    run_one(64'h8000_0000_0000_0001, lat, d);
    n_checks++; if (d !== 16'hFF83) $display("FAIL const_neg: got %h want ff83", d); else n_pass++;
  endtask

  task automatic test_linear();
    int lat; logic [OUT_W-1:0] d;
    cfg_write(0, 0, 8192, 0);
    run_one(64'hC000_0000_0000_0000, lat, d);
    n_checks++; if (d !== 16'd512) $display("FAIL linear: got %0d want 512", d); else n_pass++;
  endtask

  task automatic test_all_zero();
    int lat; logic [OUT_W-1:0] d;
    cfg_write(8'hF7, 80, -5, 7);
    run_one(64'h0000_0000_0000_0006, lat, d);
    n_checks++; if (d !== 16'd10) $display("FAIL all_zero_seg: got %0d want 10", d); else n_pass++;
  endtask

  // Second sample sees the new entry; the first, whose table read lands on
  // the same edge as the write, must still see the old one.
  task automatic test_cfg_rbw();
    logic [OUT_W-1:0] got_q[$];
    cfg_write(4, 800, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h4000_0000_0000_0000; out_ready = 1'b1;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 8'd4; cfg_data = {18'd0, 18'd0, 18'd1600};
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; m_c0[4] = 1600;
    for (int cyc = 0; cyc < 20 && got_q.size() < 2; cyc++) begin
      if (out_valid) got_q.push_back(out_data);
      @(negedge clk);
    end
    n_checks++; if (got_q.size() != 2) $display("FAIL rbw_count: got %0d want 2", got_q.size()); else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++; if (got_q[0] !== 16'd100) $display("FAIL rbw_old: got %0d want 100", got_q[0]); else n_pass++;
      n_checks++; if (got_q[1] !== 16'd200) $display("FAIL rbw_new: got %0d want 200", got_q[1]); else n_pass++;
    end
  endtask

  task automatic load_table_random();
    for (int a = 0; a < 2 ** ADDR_W; a++)
      cfg_write(a, int'($urandom_range(0, 262143)),
                int'($urandom_range(0, 262143)) - 131072,
                int'($urandom_range(0, 262143)) - 131072);
  endtask

  task automatic test_backpressure();
    logic [IN_W-1:0]  us[20];
    logic [OUT_W-1:0] exp_q[$], got_q[$];
    logic [OUT_W-1:0] held;
    logic stalled_prev;
    int sent, bad_ready, bad_hold, stall_cycles;
    for (int i = 0; i < 20; i++) us[i] = gen_u();
    sent = 0; bad_ready = 0; bad_hold = 0; stall_cycles = 0;
    stalled_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 80 && got_q.size() < 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 8 && cyc <= 17);
      in_valid  = (sent < 20);
      in_data   = (sent < 20) ? us[sent] : '0;
      #1;
      if (out_valid && !out_ready) stall_cycles++;
      if (out_valid && !out_ready && in_ready) bad_ready++;
      if (stalled_prev && (out_data !== held || !out_valid)) bad_hold++;
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin exp_q.push_back(model(in_data)); sent++; end
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (stall_cycles != 10) $display("FAIL bp_stall_cycles: got %0d want 10", stall_cycles); else n_pass++;
    n_checks++; if (bad_ready != 0) $display("FAIL bp_in_ready_low: %0d stall cycles with in_ready=1, want 0", bad_ready); else n_pass++;
    n_checks++; if (bad_hold != 0) $display("FAIL bp_output_hold: %0d unstable stall cycles, want 0", bad_hold); else n_pass++;
    n_checks++; if (got_q.size() != 20) $display("FAIL bp_count: got %0d want 20", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL bp_sample[%0d]: missing, want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL bp_sample[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] exp_q[$], got_q[$];
    logic [IN_W-1:0]  u;
    int sent, bad_ready;
    sent = 0; bad_ready = 0; u = gen_u();
    for (int cyc = 0; cyc < 3000 && got_q.size() < 300; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      in_data   = u;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (in_ready !== (out_ready || !out_valid)) bad_ready++;
      if (in_valid && in_ready) begin exp_q.push_back(model(in_data)); sent++; u = gen_u(); end
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (bad_ready != 0) $display("FAIL rnd_in_ready: %0d wrong cycles, want 0", bad_ready); else n_pass++;
    n_checks++; if (got_q.size() != 300) $display("FAIL rnd_count: got %0d want 300", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL rnd_sample[%0d]: missing, want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL rnd_sample[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [OUT_W-1:0] d;
    cfg_write(0, 1000, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h8000_0000_0000_0000; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL reset_mid_leak: %0d samples emerged, want 0", seen); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_mid_data: got %h want 0000", out_data); else n_pass++;
    run_one(64'h8000_0000_0000_0000, lat, d);
    n_checks++; if (d !== 16'd125) $display("FAIL reset_mid_resume: got %0d want 125", d); else n_pass++;
  endtask

  task automatic test_saturation();
    int lat; logic [OUT_W-1:0] d;
`ifdef GNG_INTERP_SAT_EN
    logic [OUT_W-1:0] want_d = 16'd32767;
    logic             want_f = 1'b1;
`else
    logic [OUT_W-1:0] want_d = 16'd0;
    logic             want_f = 1'b0;
`endif
    do_reset();
    n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_pre: got %b want 0", sat_flag); else n_pass++;
    cfg_write(0, 262143, 0, 0);
    run_one(64'h8000_0000_0000_0000, lat, d);
    n_checks++; if (d !== want_d) $display("FAIL sat_value: got %0d want %0d", d, want_d); else n_pass++;
    n_checks++; if (sat_flag !== want_f) $display("FAIL sat_flag_rise: got %b want %b", sat_flag, want_f); else n_pass++;
    cfg_write(0, 1000, 0, 0);
    run_one(64'h8000_0000_0000_0000, lat, d);
    n_checks++; if (d !== 16'd125) $display("FAIL sat_after_value: got %0d want 125", d); else n_pass++;
    n_checks++; if (sat_flag !== want_f) $display("FAIL sat_flag_sticky: got %b want %b", sat_flag, want_f); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_constant();
    test_linear();
    test_all_zero();
    test_cfg_rbw();
    load_table_random();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
